// File: rtl/nios2_debug_slave_cmd_sync.sv
`default_nettype none
// ============================================================================
// Module   : nios2_debug_slave_cmd_sync
// Brief    : System-clock-side command receiver for the Nios II JTAG debug
//            slave. Synchronises the vs_uir / vs_e1dr strobes, queues
//            {IR, scan} commands in a small FIFO and replays each one as a
//            held jdo word plus a one-hot take_action / take_no_action pulse.
// Option   : define NIOS2_DEBUG_SLAVE_CMD_TS_EN to timestamp every queued
//            command and expose it on cmd_ts.
// Revision : 1.0 - initial release
// ============================================================================
module nios2_debug_slave_cmd_sync #(
   parameter int SR_WIDTH    = 38,
   parameter int IR_WIDTH    = 2,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int ACTION_BIT  = 34,
   parameter int TS_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [IR_WIDTH-1:0]      ir_in,
   input  logic [SR_WIDTH-1:0]      sr,
   input  logic                     vs_uir,
   input  logic                     vs_e1dr,
   input  logic                     cmd_ready,
   input  logic                     ovf_clr,
   output logic [SR_WIDTH-1:0]      jdo,
   output logic [2**IR_WIDTH-1:0]   take_action,
   output logic [2**IR_WIDTH-1:0]   take_no_action,
   output logic [IR_WIDTH-1:0]      ir_cur,
   output logic                     fifo_empty,
`ifdef NIOS2_DEBUG_SLAVE_CMD_TS_EN
   output logic [TS_WIDTH-1:0]      cmd_ts,
`endif
   output logic                     overflow
);

   localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
   localparam int c_LANES  = 2**IR_WIDTH;
`ifdef NIOS2_DEBUG_SLAVE_CMD_TS_EN
   localparam int c_ENTRY_W = TS_WIDTH + IR_WIDTH + SR_WIDTH;
`else
   localparam int c_ENTRY_W = IR_WIDTH + SR_WIDTH;
`endif
   localparam logic [c_ADDR_W:0]  c_PTR_ONE  = (c_ADDR_W+1)'(1);
   localparam logic [c_LANES-1:0] c_LANE_ONE = c_LANES'(1);

   generate
      if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 ||
          TS_WIDTH < 1 || ACTION_BIT >= SR_WIDTH) begin : g_param_check
         $error("nios2_debug_slave_cmd_sync: illegal parameter combination");
      end
   endgenerate

   // Synchroniser, edge-detect and arming state
   logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d, e1dr_sync_q, e1dr_sync_d;
   logic [SYNC_STAGES-1:0] prime_q, prime_d;
   logic                   uir_dly_q, uir_dly_d, e1dr_dly_q, e1dr_dly_d;
   logic                   uir_arm_q, uir_arm_d, e1dr_arm_q, e1dr_arm_d;
   // Command and queue state
   logic [IR_WIDTH-1:0]    ir_cur_q, ir_cur_d;
   logic [c_ADDR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [SR_WIDTH-1:0]    jdo_q, jdo_d;
   logic [c_LANES-1:0]     act_q, act_d, noact_q, noact_d;
   logic                   overflow_q, overflow_d;
   logic [c_ENTRY_W-1:0]   mem_q [FIFO_DEPTH];

   logic                   w_uir_out, w_e1dr_out, w_primed, w_uir_p, w_e1dr_p;
   logic                   w_full, w_empty, w_pop, w_push, w_drop;
   logic [IR_WIDTH-1:0]    w_ir_sel, w_head_ir;
   logic [SR_WIDTH-1:0]    w_head_sr;
   logic [c_ENTRY_W-1:0]   w_entry, w_head;
   logic [c_LANES-1:0]     w_lane;

`ifdef NIOS2_DEBUG_SLAVE_CMD_TS_EN
   logic [TS_WIDTH-1:0]    ts_q, ts_d, cmd_ts_q, cmd_ts_d;
`endif

   // Strobe synchronisers and rising-edge detectors. The prime chain marks
   // when the sync chains hold real post-reset samples; an edge detector is
   // armed only after it has seen its strobe low, so a level that is already
   // high at reset release cannot masquerade as a new rising edge.
   always_comb begin
      uir_sync_d  = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      e1dr_sync_d = {e1dr_sync_q[SYNC_STAGES-2:0], vs_e1dr};
      prime_d     = {prime_q[SYNC_STAGES-2:0], 1'b1};
      w_primed    = prime_q[SYNC_STAGES-1];
      w_uir_out   = uir_sync_q[SYNC_STAGES-1];
      w_e1dr_out  = e1dr_sync_q[SYNC_STAGES-1];
      uir_dly_d   = w_uir_out;
      e1dr_dly_d  = w_e1dr_out;
      uir_arm_d   = uir_arm_q  | (w_primed & ~w_uir_out);
      e1dr_arm_d  = e1dr_arm_q | (w_primed & ~w_e1dr_out);
      w_uir_p     = w_uir_out  & ~uir_dly_q  & uir_arm_q;
      w_e1dr_p    = w_e1dr_out & ~e1dr_dly_q & e1dr_arm_q;
   end

   // Queue control, IR tracking and registered command issue
   always_comb begin
      w_empty  = (wr_ptr_q == rd_ptr_q);
      w_full   = (wr_ptr_q[c_ADDR_W] != rd_ptr_q[c_ADDR_W]) &&
                 (wr_ptr_q[c_ADDR_W-1:0] == rd_ptr_q[c_ADDR_W-1:0]);
      w_pop    = ~w_empty & cmd_ready;
      // A pop on the same edge frees a slot, so a full queue still accepts.
      w_push   = w_e1dr_p & (~w_full | w_pop);
      w_drop   = w_e1dr_p & w_full & ~w_pop;
      w_ir_sel = w_uir_p ? ir_in : ir_cur_q;
`ifdef NIOS2_DEBUG_SLAVE_CMD_TS_EN
      w_entry  = {ts_q, w_ir_sel, sr};
`else
      w_entry  = {w_ir_sel, sr};
`endif
      w_head    = mem_q[rd_ptr_q[c_ADDR_W-1:0]];
      w_head_sr = w_head[SR_WIDTH-1:0];
      w_head_ir = w_head[SR_WIDTH +: IR_WIDTH];
      w_lane    = c_LANE_ONE << w_head_ir;

      ir_cur_d   = w_uir_p ? ir_in : ir_cur_q;
      wr_ptr_d   = w_push ? wr_ptr_q + c_PTR_ONE : wr_ptr_q;
      rd_ptr_d   = w_pop  ? rd_ptr_q + c_PTR_ONE : rd_ptr_q;
      overflow_d = w_drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
      jdo_d      = jdo_q;
      act_d      = '0;
      noact_d    = '0;
      if (w_pop) begin
         jdo_d = w_head_sr;
         if (w_head_sr[ACTION_BIT]) act_d   = w_lane;
         else                       noact_d = w_lane;
      end
`ifdef NIOS2_DEBUG_SLAVE_CMD_TS_EN
      ts_d     = ts_q + TS_WIDTH'(1);
      cmd_ts_d = w_pop ? w_head[IR_WIDTH+SR_WIDTH +: TS_WIDTH] : cmd_ts_q;
`endif
   end

   // All control and output flops, cleared by the asynchronous reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         uir_sync_q  <= '0;
         e1dr_sync_q <= '0;
         prime_q     <= '0;
         uir_dly_q   <= 1'b0;
         e1dr_dly_q  <= 1'b0;
         uir_arm_q   <= 1'b0;
         e1dr_arm_q  <= 1'b0;
         ir_cur_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         jdo_q       <= '0;
         act_q       <= '0;
         noact_q     <= '0;
         overflow_q  <= 1'b0;
`ifdef NIOS2_DEBUG_SLAVE_CMD_TS_EN
         ts_q        <= '0;
         cmd_ts_q    <= '0;
`endif
      end else begin
         uir_sync_q  <= uir_sync_d;
         e1dr_sync_q <= e1dr_sync_d;
         prime_q     <= prime_d;
         uir_dly_q   <= uir_dly_d;
         e1dr_dly_q  <= e1dr_dly_d;
         uir_arm_q   <= uir_arm_d;
         e1dr_arm_q  <= e1dr_arm_d;
         ir_cur_q    <= ir_cur_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         jdo_q       <= jdo_d;
         act_q       <= act_d;
         noact_q     <= noact_d;
         overflow_q  <= overflow_d;
`ifdef NIOS2_DEBUG_SLAVE_CMD_TS_EN
         ts_q        <= ts_d;
         cmd_ts_q    <= cmd_ts_d;
`endif
      end
   end

   // Queue storage; never read while empty, so it needs no reset
   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q[c_ADDR_W-1:0]] <= w_entry;
   end

   assign jdo            = jdo_q;
   assign take_action    = act_q;
   assign take_no_action = noact_q;
   assign ir_cur         = ir_cur_q;
   assign fifo_empty     = w_empty;
   assign overflow       = overflow_q;
`ifdef NIOS2_DEBUG_SLAVE_CMD_TS_EN
   assign cmd_ts         = cmd_ts_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nios2_debug_slave_cmd_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_debug_slave_cmd_sync
// Brief    : Directed, table-driven bench for nios2_debug_slave_cmd_sync
//            (default parameters: 2-bit IR, 38-bit scan, 2 sync stages,
//            4-entry queue, action bit 34).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios2_debug_slave_cmd_sync;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic        vs_uir, vs_e1dr, cmd_ready, ovf_clr;
   logic [37:0] jdo;
   logic [3:0]  take_action, take_no_action;
   logic [1:0]  ir_cur;
   logic        fifo_empty, overflow;
`ifdef NIOS2_DEBUG_SLAVE_CMD_TS_EN
   logic [15:0] cmd_ts;
   int          cyc;
`endif

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] sr;
      bit          sep;        // 1: IR loaded by an earlier vs_uir; 0: vs_uir and vs_e1dr rise together
      logic [3:0]  exp_act;
      logic [3:0]  exp_noact;
   } vec_t;

   vec_t vecs [5];

   nios2_debug_slave_cmd_sync dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ir_in          (ir_in),
      .sr             (sr),
      .vs_uir         (vs_uir),
      .vs_e1dr        (vs_e1dr),
      .cmd_ready      (cmd_ready),
      .ovf_clr        (ovf_clr),
      .jdo            (jdo),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .ir_cur         (ir_cur),
      .fifo_empty     (fifo_empty),
`ifdef NIOS2_DEBUG_SLAVE_CMD_TS_EN
      .cmd_ts         (cmd_ts),
`endif
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   // Pulses last one full cycle, so sampling on the falling edge sees each once
   always @(negedge clk) begin
      if ((|take_action) || (|take_no_action)) pulse_cnt <= pulse_cnt + 1;
   end

`ifdef NIOS2_DEBUG_SLAVE_CMD_TS_EN
   // Mirror of the free-running timestamp: edges seen since reset release
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end
`endif

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic e1dr_cmd(input logic [37:0] val);
      sr      = val;
      vs_e1dr = 1'b1;
      repeat (3) tick();
      vs_e1dr = 1'b0;
      repeat (4) tick();
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      if (v.sep) begin
         ir_in  = v.ir;
         vs_uir = 1'b1;
         repeat (5) tick();
         vs_uir = 1'b0;
         ir_in  = ~v.ir;            // must not be used: the command takes ir_cur
         repeat (4) tick();
         chk($sformatf("v%0d_ir_cur_pre", idx), 64'(ir_cur), 64'(v.ir));
         sr      = v.sr;
         vs_e1dr = 1'b1;
      end else begin
         ir_in   = v.ir;
         sr      = v.sr;
         vs_uir  = 1'b1;
         vs_e1dr = 1'b1;
      end
      tick();                                          // edge k
      tick();                                          // edge k+1
      chk($sformatf("v%0d_early_k1", idx), 64'({take_action, take_no_action}), 64'(0));
      tick();                                          // edge k+2
      chk($sformatf("v%0d_early_k2", idx), 64'({take_action, take_no_action}), 64'(0));
      tick();                                          // edge k+3
      chk($sformatf("v%0d_act", idx),   64'(take_action),    64'(v.exp_act));
      chk($sformatf("v%0d_noact", idx), 64'(take_no_action), 64'(v.exp_noact));
      chk($sformatf("v%0d_jdo", idx),   64'(jdo),            64'(v.sr));
      tick();
      chk($sformatf("v%0d_pulse_end", idx), 64'({take_action, take_no_action}), 64'(0));
      chk($sformatf("v%0d_jdo_hold", idx),  64'(jdo), 64'(v.sr));
      vs_uir  = 1'b0;
      vs_e1dr = 1'b0;
      repeat (4) tick();
      chk($sformatf("v%0d_ir_cur", idx), 64'(ir_cur), 64'(v.ir));
   endtask

   initial begin
      int base;
      int guard;

      vecs[0] = '{ir: 2'b01, sr: 38'h04_0000_1234, sep: 1'b1, exp_act: 4'b0010, exp_noact: 4'b0000};
      vecs[1] = '{ir: 2'b10, sr: 38'h00_0000_0ABC, sep: 1'b0, exp_act: 4'b0000, exp_noact: 4'b0100};
      vecs[2] = '{ir: 2'b11, sr: 38'h3F_FFFF_FFFF, sep: 1'b1, exp_act: 4'b1000, exp_noact: 4'b0000};
      vecs[3] = '{ir: 2'b00, sr: 38'h3B_FFFF_FFFF, sep: 1'b0, exp_act: 4'b0000, exp_noact: 4'b0001};
      vecs[4] = '{ir: 2'b01, sr: 38'h04_0000_0000, sep: 1'b0, exp_act: 4'b0010, exp_noact: 4'b0000};

      reset_n   = 1'b0;
      ir_in     = '0;
      sr        = '0;
      vs_uir    = 1'b0;
      vs_e1dr   = 1'b0;
      cmd_ready = 1'b1;
      ovf_clr   = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_jdo",        64'(jdo),            64'(0));
      chk("rst_act",        64'(take_action),    64'(0));
      chk("rst_noact",      64'(take_no_action), 64'(0));
      chk("rst_ir_cur",     64'(ir_cur),         64'(0));
      chk("rst_fifo_empty", 64'(fifo_empty),     64'(1));
      chk("rst_overflow",   64'(overflow),       64'(0));

      reset_n = 1'b1;
      repeat (6) tick();

      // Table-driven single commands
      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);
      chk("vec_pulse_count", 64'(pulse_cnt), 64'(5));

      // Overflow: 5 commands while stalled, ir_cur = 01 so lane 1, no-action
      cmd_ready = 1'b0;
      base = pulse_cnt;
      for (int i = 1; i <= 4; i++) e1dr_cmd(38'(i));
      chk("ovf_not_yet", 64'(overflow), 64'(0));
      chk("ovf_queued",  64'(fifo_empty), 64'(0));
      e1dr_cmd(38'd5);
      chk("ovf_set",       64'(overflow), 64'(1));
      chk("ovf_jdo_hold",  64'(jdo), 64'(38'h04_0000_0000));
      chk("ovf_no_pulses", 64'(pulse_cnt - base), 64'(0));
      cmd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("drain%0d_jdo", i),   64'(jdo), 64'(i));
         chk($sformatf("drain%0d_noact", i), 64'(take_no_action), 64'(4'b0010));
         chk($sformatf("drain%0d_act", i),   64'(take_action), 64'(0));
      end
      tick();
      chk("drain_done_pulse", 64'({take_action, take_no_action}), 64'(0));
      chk("drain_done_empty", 64'(fifo_empty), 64'(1));
      chk("ovf_sticky",       64'(overflow), 64'(1));
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf_cleared", 64'(overflow), 64'(0));

      // Full queue: push and pop on the same edge must not drop
      cmd_ready = 1'b0;
      for (int i = 11; i <= 14; i++) e1dr_cmd(38'(i));
      sr      = 38'd15;
      vs_e1dr = 1'b1;
      tick();                                          // edge k
      tick();                                          // edge k+1
      cmd_ready = 1'b1;
      tick();                                          // edge k+2: pop and push together
      vs_e1dr = 1'b0;
      chk("full_pp_jdo", 64'(jdo), 64'(11));
      chk("full_pp_ovf", 64'(overflow), 64'(0));
      for (int i = 12; i <= 15; i++) begin
         tick();
         chk($sformatf("full_pp_order%0d", i), 64'(jdo), 64'(i));
      end
      tick();
      chk("full_pp_empty",   64'(fifo_empty), 64'(1));
      chk("full_pp_ovf_end", 64'(overflow), 64'(0));

      // Held level yields one command
      base    = pulse_cnt;
      sr      = 38'h04_0000_00AA;
      vs_e1dr = 1'b1;
      repeat (20) tick();
      vs_e1dr = 1'b0;
      repeat (5) tick();
      chk("held_one_cmd", 64'(pulse_cnt - base), 64'(1));
      chk("held_jdo",     64'(jdo), 64'(38'h04_0000_00AA));

      // Reset with queued commands, strobe high through release
      cmd_ready = 1'b0;
      e1dr_cmd(38'd21);
      e1dr_cmd(38'd22);
      e1dr_cmd(38'd23);
      chk("rq_queued", 64'(fifo_empty), 64'(0));
      sr      = 38'd24;
      vs_e1dr = 1'b1;
      tick();
      reset_n = 1'b0;
      #1;
      chk("rq_empty_now",  64'(fifo_empty), 64'(1));
      chk("rq_jdo_clear",  64'(jdo), 64'(0));
      chk("rq_ir_clear",   64'(ir_cur), 64'(0));
      cmd_ready = 1'b1;
      base = pulse_cnt;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (10) tick();
      chk("rq_no_pulses", 64'(pulse_cnt - base), 64'(0));
      chk("rq_no_push",   64'(fifo_empty), 64'(1));
      vs_e1dr = 1'b0;
      repeat (4) tick();
      sr      = 38'h04_0000_0077;
      vs_e1dr = 1'b1;
      repeat (3) tick();                               // edges k..k+2
      chk("rq_rearm_early", 64'({take_action, take_no_action}), 64'(0));
      tick();                                          // edge k+3
      chk("rq_rearm_act", 64'(take_action), 64'(4'b0001));
      chk("rq_rearm_jdo", 64'(jdo), 64'(38'h04_0000_0077));
      vs_e1dr = 1'b0;
      repeat (4) tick();

`ifdef NIOS2_DEBUG_SLAVE_CMD_TS_EN
      // Timestamp wrap: pushes land at counter FFFE and (after wrap) 0001
      guard = 0;
      while (cyc != 32'hFFFC && guard < 70000) begin
         tick();
         guard++;
      end
      chk("ts_reach_target", 64'(cyc), 64'(32'hFFFC));
      sr      = 38'h04_0000_0001;
      vs_e1dr = 1'b1;
      tick();                                          // edge k
      vs_e1dr = 1'b0;
      tick();                                          // edge k+1
      tick();                                          // edge k+2: push @ FFFE
      vs_e1dr = 1'b1;
      tick();                                          // edge k+3: issue
      chk("ts_first", 64'(cmd_ts), 64'(16'hFFFE));
      vs_e1dr = 1'b0;
      tick();                                          // edge k+4
      tick();                                          // edge k+5: push @ 0001
      tick();                                          // edge k+6: issue
      chk("ts_wrap", 64'(cmd_ts), 64'(16'h0001));
`else
      guard = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors + guard * 0);
      $finish;
   end

endmodule
`default_nettype wire
